// File: rtl/fmc_adc_serial_pattern_gen.sv
// FMC ADC serial test-pattern source: per-frame waveform generator with bit-pair lane serialiser.
module fmc_adc_serial_pattern_gen #(
   parameter int unsigned g_NB_CHANNELS = 4,
   parameter int unsigned g_RESOLUTION  = 14,
   parameter int unsigned g_FRAME_LEN   = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  en_i,
   input  logic [1:0]                            mode_i,
   input  logic [g_RESOLUTION-1:0]               step_i,
   input  logic [g_RESOLUTION-1:0]               limit_i,
   input  logic [g_RESOLUTION-1:0]               const_i,
   input  logic [g_RESOLUTION-1:0]               ch_offset_i,
   output logic [g_NB_CHANNELS-1:0]              dat_odd_o,
   output logic [g_NB_CHANNELS-1:0]              dat_even_o,
   output logic                                  fr_o,
   output logic [g_NB_CHANNELS*g_RESOLUTION-1:0] sample_o,
   output logic                                  sample_valid_o,
   output logic [31:0]                           frame_cnt_o
);

   localparam int unsigned c_SLOT_W = $clog2(g_FRAME_LEN + 1);
   localparam int unsigned c_RES_W  = g_RESOLUTION;
   localparam int unsigned c_SMP_W  = g_NB_CHANNELS * g_RESOLUTION;
   localparam logic [c_SLOT_W-1:0] c_LAST_SLOT  = c_SLOT_W'(g_FRAME_LEN - 1);
   localparam logic [c_SLOT_W-1:0] c_FR_SLOTS   = c_SLOT_W'(g_FRAME_LEN / 2);
   localparam logic [c_SLOT_W-1:0] c_DATA_SLOTS = c_SLOT_W'(g_RESOLUTION / 2);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   // r_slot is the slot that the next clock edge drives onto the outputs
   logic [c_SLOT_W-1:0]      r_slot;
   dir_t                     r_dir;
   logic [c_RES_W-1:0]       r_base;
   logic [6:0]               r_lfsr;
   logic                     r_frame_en;
   logic                     r_fr;
   logic [g_NB_CHANNELS-1:0] r_odd;
   logic [g_NB_CHANNELS-1:0] r_even;
   logic [c_SMP_W-1:0]       r_sample;
   logic                     r_valid;
   logic [31:0]              r_frame_cnt;

   logic                     w_frame_start;
   logic                     w_frame_en;
   dir_t                     w_dir_next;
   logic [c_RES_W-1:0]       w_base_next;
   logic [6:0]               w_lfsr_next;
   logic signed [c_RES_W+1:0] w_b_ext;
   logic signed [c_RES_W+1:0] w_lim_ext;
   logic                     w_over;
   logic                     w_under;
   logic [c_RES_W-1:0]       w_acc;
   logic [c_SMP_W-1:0]       w_new_sample;
   logic [c_SMP_W-1:0]       w_src;
   logic [c_RES_W-1:0]       w_ch;
   logic [g_NB_CHANNELS-1:0] w_odd;
   logic [g_NB_CHANNELS-1:0] w_even;

   assign w_frame_start = (r_slot == '0);
   // enable is decided at the frame start; dropping en_i mid-frame still blanks the lanes at once
   assign w_frame_en    = w_frame_start ? en_i : r_frame_en;

   // triangle turn-around test on the old base value, in a widened signed domain
   assign w_b_ext   = {{2{r_base[c_RES_W-1]}}, r_base};
   assign w_lim_ext = {2'b00, limit_i};
   assign w_over    = (w_b_ext > w_lim_ext);
   assign w_under   = (w_b_ext < -w_lim_ext);

   // next base value, direction and LFSR for the selected waveform
   always_comb begin
      w_dir_next  = r_dir;
      w_base_next = r_base;
      w_lfsr_next = r_lfsr;
      case (mode_i)
         2'd0: begin
            if (w_over || w_under) begin
               w_dir_next = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
            end
            w_base_next = (w_dir_next == DIR_UP) ? (r_base + step_i) : (r_base - step_i);
         end
         2'd1:    w_base_next = r_base + step_i;
         2'd2:    w_base_next = const_i;
         default: begin
            w_base_next = c_RES_W'(r_lfsr);
            w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
         end
      endcase
   end

   // per-channel samples: channel n = base + n*offset, built by repeated addition
   always_comb begin
      w_acc        = r_base;
      w_new_sample = '0;
      for (int n = 0; n < int'(g_NB_CHANNELS); n++) begin
         w_new_sample[n*g_RESOLUTION +: g_RESOLUTION] = w_acc;
         w_acc = w_acc + ch_offset_i;
      end
   end

   // lane bits for the slot being driven; slot 0 uses the sample being latched in the same edge
   always_comb begin
      w_src  = w_frame_start ? w_new_sample : r_sample;
      w_ch   = '0;
      w_odd  = '0;
      w_even = '0;
      for (int n = 0; n < int'(g_NB_CHANNELS); n++) begin
         w_ch      = w_src[n*g_RESOLUTION +: g_RESOLUTION] << {r_slot, 1'b0};
         w_odd[n]  = w_ch[c_RES_W-1];
         w_even[n] = w_ch[c_RES_W-2];
      end
      if (!(r_slot < c_DATA_SLOTS) || !w_frame_en || !en_i) begin
         w_odd  = '0;
         w_even = '0;
      end
   end

   // slot counter, frame clock and serial lanes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_slot <= '0;
         r_fr   <= 1'b0;
         r_odd  <= '0;
         r_even <= '0;
      end else begin
         r_slot <= (r_slot == c_LAST_SLOT) ? '0 : (r_slot + c_SLOT_W'(1));
         r_fr   <= (r_slot < c_FR_SLOTS);
         r_odd  <= w_odd;
         r_even <= w_even;
      end
   end

   // frame-start bookkeeping: counter, enable capture, waveform state and parallel sample
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_frame_cnt <= '0;
         r_frame_en  <= 1'b0;
         r_valid     <= 1'b0;
         r_sample    <= '0;
         r_base      <= '0;
         r_dir       <= DIR_UP;
         r_lfsr      <= 7'h7F;
      end else begin
         r_valid <= w_frame_start & en_i;
         if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
            r_frame_en  <= en_i;
            if (en_i) begin
               r_sample <= w_new_sample;
               r_base   <= w_base_next;
               r_dir    <= w_dir_next;
               r_lfsr   <= w_lfsr_next;
            end
         end
      end
   end

   assign dat_odd_o      = r_odd;
   assign dat_even_o     = r_even;
   assign fr_o           = r_fr;
   assign sample_o       = r_sample;
   assign sample_valid_o = r_valid;
   assign frame_cnt_o    = r_frame_cnt;

endmodule

// File: tb/tb_fmc_adc_serial_pattern_gen.sv
// Self-checking bench for fmc_adc_serial_pattern_gen with a frame-level reference model.
module tb_fmc_adc_serial_pattern_gen;

   localparam int NB  = 4;
   localparam int R   = 14;
   localparam int FL  = 8;
   localparam int NB8 = 2;
   localparam int R8  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (defaults)
   logic             rst, en;
   logic [1:0]       mode;
   logic [R-1:0]     step, limit, cst, off;
   logic [NB-1:0]    odd, even;
   logic             fr, vld;
   logic [NB*R-1:0]  smp;
   logic [31:0]      cnt;

   // 8-bit instance
   logic             en8;
   logic [1:0]       mode8;
   logic [R8-1:0]    step8, limit8, cst8, off8;
   logic [NB8-1:0]   odd8, even8;
   logic             fr8, vld8;
   logic [NB8*R8-1:0] smp8;
   logic [31:0]      cnt8;

   fmc_adc_serial_pattern_gen #(.g_NB_CHANNELS(NB), .g_RESOLUTION(R), .g_FRAME_LEN(FL)) u_dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .step_i(step), .limit_i(limit),
      .const_i(cst), .ch_offset_i(off), .dat_odd_o(odd), .dat_even_o(even), .fr_o(fr),
      .sample_o(smp), .sample_valid_o(vld), .frame_cnt_o(cnt));

   fmc_adc_serial_pattern_gen #(.g_NB_CHANNELS(NB8), .g_RESOLUTION(R8), .g_FRAME_LEN(FL)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .en_i(en8), .mode_i(mode8), .step_i(step8), .limit_i(limit8),
      .const_i(cst8), .ch_offset_i(off8), .dat_odd_o(odd8), .dat_even_o(even8), .fr_o(fr8),
      .sample_o(smp8), .sample_valid_o(vld8), .frame_cnt_o(cnt8));

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state (main instance)
   logic [R-1:0] m_b;
   bit           m_up;
   logic [6:0]   m_lfsr;
   int           m_cnt;

   // per-frame observations
   logic            obs_valid, exp_valid;
   logic [NB*R-1:0] obs_sample, exp_sample;
   logic [31:0]     obs_cnt;
   logic [FL-1:0]   obs_fr;
   logic            obs_tail_nz, obs_lane_nz;
   logic [R-1:0]    obs_des [NB];
   logic            obs8_valid;
   logic [NB8*R8-1:0] obs8_sample;
   logic [R8-1:0]   obs8_des [NB8];

   localparam logic [FL-1:0] FR_PAT = 8'h0F;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_b    = '0;
      m_up   = 1'b1;
      m_lfsr = 7'h7F;
      m_cnt  = 0;
   endtask

   // drive one frame's inputs ahead of slot 0, observe all slots, then advance the model
   task automatic run_frame(input logic a_en, input logic [1:0] a_md, input logic [R-1:0] a_st,
                            input logic [R-1:0] a_lim, input logic [R-1:0] a_cs, input logic [R-1:0] a_off,
                            input int mid_slot, input logic [1:0] mid_md, input logic mid_en);
      int bs, li;
      en = a_en; mode = a_md; step = a_st; limit = a_lim; cst = a_cs; off = a_off;
      for (int k = 0; k < FL; k++) begin
         tick();
         if (k == 0) begin
            obs_valid   = vld;
            obs_sample  = smp;
            obs_cnt     = cnt;
            obs8_valid  = vld8;
            obs8_sample = smp8;
            obs_tail_nz = 1'b0;
            obs_lane_nz = 1'b0;
            for (int n = 0; n < NB; n++) obs_des[n] = '0;
            for (int n = 0; n < NB8; n++) obs8_des[n] = '0;
         end
         obs_fr[k] = fr;
         if ((odd != '0) || (even != '0)) obs_lane_nz = 1'b1;
         if (k < R/2) begin
            for (int n = 0; n < NB; n++) obs_des[n] = {obs_des[n][R-3:0], odd[n], even[n]};
         end else if ((odd != '0) || (even != '0)) begin
            obs_tail_nz = 1'b1;
         end
         if (k < R8/2) begin
            for (int n = 0; n < NB8; n++) obs8_des[n] = {obs8_des[n][R8-3:0], odd8[n], even8[n]};
         end
         if (k == mid_slot) begin
            mode = mid_md;
            en   = mid_en;
         end
      end
      m_cnt++;
      exp_valid  = a_en;
      exp_sample = '0;
      if (a_en) begin
         for (int n = 0; n < NB; n++) exp_sample[n*R +: R] = m_b + R'(n) * a_off;
         case (a_md)
            2'd0: begin
               bs = int'($signed(m_b));
               li = int'(a_lim);
               if (bs > li || bs < -li) m_up = !m_up;
               m_b = m_up ? (m_b + a_st) : (m_b - a_st);
            end
            2'd1: m_b = m_b + a_st;
            2'd2: m_b = a_cs;
            default: begin
               m_b    = R'(m_lfsr);
               m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            end
         endcase
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 0; mode = 0; step = 0; limit = 0; cst = 0; off = 0;
      en8 = 0; mode8 = 0; step8 = 0; limit8 = 0; cst8 = 0; off8 = 0;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) #2; else begin tick(); tick(); tick(); end
         n_cmp++; if (fr !== 1'b0)   begin n_fail++; $display("FAIL reset_fr[%0d] got %b exp 0", i, fr); end
         n_cmp++; if (odd !== '0)    begin n_fail++; $display("FAIL reset_odd[%0d] got %h exp 0", i, odd); end
         n_cmp++; if (even !== '0)   begin n_fail++; $display("FAIL reset_even[%0d] got %h exp 0", i, even); end
         n_cmp++; if (smp !== '0)    begin n_fail++; $display("FAIL reset_sample[%0d] got %h exp 0", i, smp); end
         n_cmp++; if (vld !== 1'b0)  begin n_fail++; $display("FAIL reset_valid[%0d] got %b exp 0", i, vld); end
         n_cmp++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt[%0d] got %0d exp 0", i, cnt); end
      end
      rst = 1'b0;
      model_reset();
   endtask

   // main instance disabled while the 8-bit instance ramps through a wrap
   task automatic test_ramp8();
      logic [R8-1:0] tab [4];
      tab[0] = 8'd0; tab[1] = 8'd100; tab[2] = 8'd200; tab[3] = 8'd44;
      en8 = 1'b1; mode8 = 2'd1; step8 = 8'd100; limit8 = 8'($urandom); cst8 = 8'($urandom); off8 = 8'd3;
      for (int f = 0; f < 4; f++) begin
         run_frame(1'b0, 2'($urandom), R'($urandom), R'($urandom), R'($urandom), R'($urandom), -1, 2'd0, 1'b0);
         n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL dis_valid f=%0d got %b exp 0", f, obs_valid); end
         n_cmp++; if (obs_lane_nz !== 1'b0) begin n_fail++; $display("FAIL dis_lanes f=%0d got nonzero exp 0", f); end
         n_cmp++; if (obs_cnt !== 32'(m_cnt)) begin n_fail++; $display("FAIL dis_cnt f=%0d got %0d exp %0d", f, obs_cnt, m_cnt); end
         n_cmp++; if (obs_fr !== FR_PAT) begin n_fail++; $display("FAIL dis_fr f=%0d got %b exp %b", f, obs_fr, FR_PAT); end
         n_cmp++; if (obs8_valid !== 1'b1) begin n_fail++; $display("FAIL r8_valid f=%0d got %b exp 1", f, obs8_valid); end
         n_cmp++; if (obs8_sample[7:0] !== tab[f]) begin n_fail++; $display("FAIL r8_ch0 f=%0d got %0d exp %0d", f, obs8_sample[7:0], tab[f]); end
         n_cmp++; if (obs8_sample[15:8] !== tab[f] + 8'd3) begin n_fail++; $display("FAIL r8_ch1 f=%0d got %0d exp %0d", f, obs8_sample[15:8], tab[f] + 8'd3); end
         n_cmp++; if (obs8_des[0] !== obs8_sample[7:0]) begin n_fail++; $display("FAIL r8_lanes f=%0d got %h exp %h", f, obs8_des[0], obs8_sample[7:0]); end
      end
      en8 = 1'b0;
   endtask

   task automatic test_triangle();
      int v, vmax, vmin;
      vmax = -100000; vmin = 100000;
      for (int f = 0; f < 170; f++) begin
         run_frame(1'b1, 2'd0, R'(8), R'(400), R'($urandom), R'($urandom), -1, 2'd0, 1'b1);
         n_cmp++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL tri_valid f=%0d got %b exp 1", f, obs_valid); end
         n_cmp++; if (obs_sample !== exp_sample) begin n_fail++; $display("FAIL tri_sample f=%0d got %h exp %h", f, obs_sample, exp_sample); end
         n_cmp++; if (obs_fr !== FR_PAT) begin n_fail++; $display("FAIL tri_fr f=%0d got %b exp %b", f, obs_fr, FR_PAT); end
         n_cmp++; if (obs_tail_nz !== 1'b0) begin n_fail++; $display("FAIL tri_tail f=%0d got nonzero exp 0", f); end
         for (int n = 0; n < NB; n++) begin
            n_cmp++; if (obs_des[n] !== obs_sample[n*R +: R]) begin n_fail++; $display("FAIL tri_lanes f=%0d ch=%0d got %h exp %h", f, n, obs_des[n], obs_sample[n*R +: R]); end
         end
         v = int'($signed(obs_sample[R-1:0]));
         if (v > vmax) vmax = v;
         if (v < vmin) vmin = v;
      end
      n_cmp++; if (vmax !== 408) begin n_fail++; $display("FAIL tri_peak got %0d exp 408", vmax); end
      n_cmp++; if (vmin !== -408) begin n_fail++; $display("FAIL tri_trough got %0d exp -408", vmin); end
   endtask

   task automatic test_constant();
      logic [NB*R-1:0] lit;
      lit = {14'h1ABF, 14'h1ABE, 14'h1ABD, 14'h1ABC};
      for (int f = 0; f < 2; f++) begin
         run_frame(1'b1, 2'd2, R'($urandom), R'($urandom), 14'h1ABC, R'(1), -1, 2'd0, 1'b1);
         n_cmp++; if (obs_sample !== exp_sample) begin n_fail++; $display("FAIL const_model f=%0d got %h exp %h", f, obs_sample, exp_sample); end
      end
      n_cmp++; if (obs_sample !== lit) begin n_fail++; $display("FAIL const_1abc got %h exp %h", obs_sample, lit); end
      n_cmp++; if (obs_tail_nz !== 1'b0) begin n_fail++; $display("FAIL const_slot7 got nonzero exp 0"); end
      for (int n = 0; n < NB; n++) begin
         n_cmp++; if (obs_des[n] !== lit[n*R +: R]) begin n_fail++; $display("FAIL const_lanes ch=%0d got %h exp %h", n, obs_des[n], lit[n*R +: R]); end
      end
      for (int f = 0; f < 6; f++) begin
         run_frame(1'b1, 2'd2, R'($urandom), R'($urandom), R'($urandom), R'($urandom), -1, 2'd0, 1'b1);
         n_cmp++; if (obs_sample !== exp_sample) begin n_fail++; $display("FAIL const_rand f=%0d got %h exp %h", f, obs_sample, exp_sample); end
      end
   endtask

   task automatic test_prbs();
      int pv [254];
      bit seen [128];
      int distinct;
      for (int f = 0; f < 255; f++) begin
         run_frame(1'b1, 2'd3, R'($urandom), R'($urandom), R'($urandom), R'($urandom), -1, 2'd0, 1'b1);
         n_cmp++; if (obs_sample !== exp_sample) begin n_fail++; $display("FAIL prbs_model f=%0d got %h exp %h", f, obs_sample, exp_sample); end
         if (f > 0) pv[f-1] = int'(obs_sample[R-1:0]);
      end
      distinct = 0;
      for (int i = 0; i < 128; i++) seen[i] = 1'b0;
      for (int i = 0; i < 127; i++) begin
         n_cmp++; if (pv[i] == 0 || pv[i] > 127) begin n_fail++; $display("FAIL prbs_range i=%0d got %0d exp 1..127", i, pv[i]); end
         n_cmp++; if (pv[i] != pv[i+127]) begin n_fail++; $display("FAIL prbs_period i=%0d got %0d exp %0d", i, pv[i+127], pv[i]); end
         if (pv[i] >= 0 && pv[i] < 128 && !seen[pv[i]]) begin seen[pv[i]] = 1'b1; distinct++; end
      end
      n_cmp++; if (distinct != 127) begin n_fail++; $display("FAIL prbs_distinct got %0d exp 127", distinct); end
   endtask

   // mid-frame mode/enable changes; columns: en, mode, mid_slot, mid_mode, mid_en
   task automatic test_enable_mode();
      logic       t_en [9];
      logic [1:0] t_md [9];
      int         t_ms [9];
      logic [1:0] t_mm [9];
      logic       t_me [9];
      logic [R-1:0] st, lim;
      t_en = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
      t_md = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
      t_ms = '{3, -1, 3, -1, -1, 2, 5, -1, -1};
      t_mm = '{2, 0, 0, 0, 0, 0, 2, 0, 0};
      t_me = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
      st  = R'($urandom_range(1, 300));
      lim = R'($urandom_range(0, 2000));
      for (int f = 0; f < 9; f++) begin
         run_frame(t_en[f], t_md[f], st, lim, R'($urandom), R'($urandom), t_ms[f], t_mm[f], t_me[f]);
         n_cmp++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL em_valid f=%0d got %b exp %b", f, obs_valid, exp_valid); end
         n_cmp++; if (obs_fr !== FR_PAT) begin n_fail++; $display("FAIL em_fr f=%0d got %b exp %b", f, obs_fr, FR_PAT); end
         n_cmp++; if (obs_cnt !== 32'(m_cnt)) begin n_fail++; $display("FAIL em_cnt f=%0d got %0d exp %0d", f, obs_cnt, m_cnt); end
         if (t_en[f]) begin
            n_cmp++; if (obs_sample !== exp_sample) begin n_fail++; $display("FAIL em_sample f=%0d got %h exp %h", f, obs_sample, exp_sample); end
         end else begin
            n_cmp++; if (obs_lane_nz !== 1'b0) begin n_fail++; $display("FAIL em_lanes f=%0d got nonzero exp 0", f); end
         end
      end
   endtask

   task automatic test_reset_pulse();
      for (int f = 0; f < 2; f++) run_frame(1'b1, 2'd2, R'($urandom), R'($urandom), 14'h2AAA, R'($urandom), -1, 2'd0, 1'b1);
      en = 1'b1; mode = 2'd2;
      for (int k = 0; k < 5; k++) tick();
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (fr !== 1'b0)   begin n_fail++; $display("FAIL rp_fr got %b exp 0", fr); end
      n_cmp++; if (odd !== '0)    begin n_fail++; $display("FAIL rp_odd got %h exp 0", odd); end
      n_cmp++; if (even !== '0)   begin n_fail++; $display("FAIL rp_even got %h exp 0", even); end
      n_cmp++; if (smp !== '0)    begin n_fail++; $display("FAIL rp_sample got %h exp 0", smp); end
      n_cmp++; if (vld !== 1'b0)  begin n_fail++; $display("FAIL rp_valid got %b exp 0", vld); end
      n_cmp++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL rp_cnt got %0d exp 0", cnt); end
      n_cmp++; if (cnt8 !== 32'd0) begin n_fail++; $display("FAIL rp_cnt8 got %0d exp 0", cnt8); end
      tick();
      n_cmp++; if (fr !== 1'b0 || cnt !== 32'd0) begin n_fail++; $display("FAIL rp_hold got fr=%b cnt=%0d exp 0/0", fr, cnt); end
      rst = 1'b0;
      model_reset();
      for (int f = 0; f < 2; f++) begin
         run_frame(1'b1, 2'd2, R'($urandom), R'($urandom), 14'h0123, R'($urandom), -1, 2'd0, 1'b1);
         n_cmp++; if (obs_cnt !== 32'(f + 1)) begin n_fail++; $display("FAIL rp_restart f=%0d got %0d exp %0d", f, obs_cnt, f + 1); end
         n_cmp++; if (obs_fr !== FR_PAT) begin n_fail++; $display("FAIL rp_fr_pat f=%0d got %b exp %b", f, obs_fr, FR_PAT); end
         n_cmp++; if (obs_sample !== exp_sample) begin n_fail++; $display("FAIL rp_sample_f f=%0d got %h exp %h", f, obs_sample, exp_sample); end
      end
      n_cmp++; if (obs_sample[R-1:0] !== 14'h0123) begin n_fail++; $display("FAIL rp_ch0 got %h exp 0123", obs_sample[R-1:0]); end
   endtask

   initial begin
      test_reset();
      test_ramp8();
      test_triangle();
      test_constant();
      test_prbs();
      test_enable_mode();
      test_reset_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fmc_adc_serial_pattern_gen.md
FMC_ADC_SERIAL_PATTERN_GEN -- requirements
Module: fmc_adc_serial_pattern_gen

Interface
REQ-001 The block SHALL have parameter g_NB_CHANNELS, default 4, number of ADC channels (1..8).
REQ-002 The block SHALL have parameter g_RESOLUTION, default 14, sample width in bits (8..16, even).
REQ-003 The block SHALL have parameter g_FRAME_LEN, default 8, bit-pair slots per frame (>= g_RESOLUTION/2, even).
REQ-004 The block SHALL have port clk_i, in, 1, the single bit-pair clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i, in, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have port en_i, in, 1, pattern enable.
REQ-007 The block SHALL have port mode_i, in, 2, waveform select: 0 triangle, 1 ramp, 2 constant, 3 PRBS7.
REQ-008 The block SHALL have port step_i, in, g_RESOLUTION, unsigned increment per frame.
REQ-009 The block SHALL have port limit_i, in, g_RESOLUTION, unsigned triangle turn-around magnitude.
REQ-010 The block SHALL have port const_i, in, g_RESOLUTION, constant-mode value (two's complement).
REQ-011 The block SHALL have port ch_offset_i, in, g_RESOLUTION, per-channel additive offset.
REQ-012 The block SHALL have port dat_odd_o, out, g_NB_CHANNELS, odd-bit lane per channel.
REQ-013 The block SHALL have port dat_even_o, out, g_NB_CHANNELS, even-bit lane per channel.
REQ-014 The block SHALL have port fr_o, out, 1, frame clock.
REQ-015 The block SHALL have port sample_o, out, g_NB_CHANNELS*g_RESOLUTION, parallel channel samples (ch0 in LSBs) for scoreboards.
REQ-016 The block SHALL have port sample_valid_o, out, 1, one-cycle pulse marking a new sample_o.
REQ-017 The block SHALL have port frame_cnt_o, out, 32, frames emitted since reset, wrapping.

Function
REQ-018 Slot counter SHALL count 0..g_FRAME_LEN-1 and wrap; slot 0 is the frame start.
REQ-019 fr_o SHALL be high in slots 0..g_FRAME_LEN/2-1 and low otherwise, regardless of en_i.
REQ-020 At each frame start the block SHALL latch mode_i, step_i, limit_i, const_i and ch_offset_i; mid-frame changes have no effect until the next frame start.
REQ-021 Base sample B (signed, g_RESOLUTION bits) SHALL update once per frame start when en_i=1 and hold when en_i=0.
REQ-022 Triangle: the block SHALL first toggle direction if B > +limit or B < -limit (old B), then B = B + step if direction is up, else B - step; the direction reset value is up.
REQ-023 Ramp: the block SHALL set B = B + step, wrapping modulo 2^g_RESOLUTION.
REQ-024 Constant: the block SHALL set B = const_i.
REQ-025 PRBS7: the block SHALL use a 7-bit LFSR x^7+x^6+1, seed 7'h7F, advanced once per frame, with B = LFSR value zero-extended.
REQ-026 Channel n sample SHALL be B + n*ch_offset, modulo 2^g_RESOLUTION.
REQ-027 Serialisation: in slot k < g_RESOLUTION/2, dat_odd_o[n] SHALL carry bit (R-1-2k) and dat_even_o[n] bit (R-2-2k) of channel n's sample; in slots k >= g_RESOLUTION/2 both lanes SHALL be 0.
REQ-028 Lane data SHALL be registered: slot-0 bits appear in the same cycle fr_o rises.
REQ-029 sample_o SHALL update, and sample_valid_o SHALL pulse, in the cycle slot 0 is driven.
REQ-030 With en_i=0 both lanes SHALL be 0, sample_valid_o SHALL stay 0, and frame_cnt_o SHALL keep counting.
REQ-031 A mode change SHALL retain B and direction; entering PRBS7 SHALL not reseed the LFSR.
REQ-032 Triangle arithmetic SHALL wrap modulo 2^g_RESOLUTION; no saturation is applied.

Reset
REQ-033 On rst_i high, asynchronously: the slot counter, B and frame_cnt_o SHALL be 0, direction SHALL be up, the LFSR SHALL be 7'h7F, and fr_o, lanes, sample_o and sample_valid_o SHALL be 0.
REQ-034 After rst_i release, the first rising clk_i edge SHALL drive slot 0, the first frame SHALL carry B=0, and the first update SHALL take effect at the second frame.
REQ-035 rst_i asserted mid-frame SHALL abort that frame immediately; no partial frame is completed.

Verification
REQ-036 Defaults, triangle, step=8, limit=400, en=1: the bench SHALL check that ch0 samples go 0, 8, ... 400, 408, 400 ... -400, -408, -400, and that the deserialised lanes equal sample_o.
REQ-037 Ramp, g_RESOLUTION=8, step=100: the bench SHALL check that the samples go 0, 100, 200, 44 (wrap).
REQ-038 Constant 14'h1ABC, ch_offset=1, 4 channels: the bench SHALL check that the channels read 1ABC, 1ABD, 1ABE, 1ABF, and that lanes are 0 in slot 7.
REQ-039 PRBS7 for 127 frames: the bench SHALL check that the sequence repeats with period 127 and never hits 0.
REQ-040 en_i toggled mid-frame, and mode_i changed in slot 3: the bench SHALL check that B holds while disabled, that the mode takes effect at the next slot 0, and that fr_o is uninterrupted.
REQ-041 rst_i pulsed in slot 4: the bench SHALL check that all outputs go 0 asynchronously and that frame_cnt_o restarts at 0.
